// File: rtl/ascon_perm_sequencer_if.sv
// Handshake and strobe bundle between the AEAD control/datapath and the
// Ascon permutation sequencer.
interface ascon_perm_sequencer_if #(
   parameter int unsigned CNT_W = 4
);
   logic             i_start;
   logic             i_has_ad;
   logic             i_blk_valid;
   logic             i_blk_last;
   logic             o_blk_ready;
   logic             o_load_init;
   logic             o_absorb;
   logic             o_round_en;
   logic [CNT_W-1:0] o_round_idx;
   logic             o_fin_key_pre;
   logic             o_enable_xor_key;
   logic             o_enable_xor_lsb;
   logic             o_tag_valid;
   logic             i_tag_ready;
   logic             o_ready;
   logic             o_busy;

   // Sequencer side
   modport slave (
      input  i_start, i_has_ad, i_blk_valid, i_blk_last, i_tag_ready,
      output o_blk_ready, o_load_init, o_absorb, o_round_en, o_round_idx,
             o_fin_key_pre, o_enable_xor_key, o_enable_xor_lsb,
             o_tag_valid, o_ready, o_busy
   );

   // Control / datapath side
   modport master (
      output i_start, i_has_ad, i_blk_valid, i_blk_last, i_tag_ready,
      input  o_blk_ready, o_load_init, o_absorb, o_round_en, o_round_idx,
             o_fin_key_pre, o_enable_xor_key, o_enable_xor_lsb,
             o_tag_valid, o_ready, o_busy
   );
endinterface

// File: rtl/ascon_perm_sequencer.sv
// Ascon AEAD pass sequencer: drives the permutation round enables, round
// constant index and end-of-permutation XOR strobes for one full pass
// (init load, p^a, key/domain XOR, AD/data absorption with p^b,
// finalization p^a, tag). Holds no state data itself.
module ascon_perm_sequencer #(
   parameter int unsigned ROUNDS_A = 12,
   parameter int unsigned ROUNDS_B = 6,
   parameter int unsigned CNT_W    = 4
) (
   input logic                   i_clk,
   input logic                   i_rst_n,
   ascon_perm_sequencer_if.slave bus
);

   typedef enum logic [3:0] {
      IDLE,
      INIT_LOAD,
      INIT_PERM,
      INIT_XOR,
      WAIT_BLK,
      BLK_PERM,
      DSEP,
      FIN_PRE,
      FIN_PERM,
      FIN_XOR,
      TAG
   } state_e;

   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(ROUNDS_A - 1);
   localparam logic [CNT_W-1:0] BLK_FIRST = CNT_W'(ROUNDS_A - ROUNDS_B);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ad_phase_q, ad_phase_d;
   logic             blk_ad_last_q, blk_ad_last_d;

   logic             ready_q, ready_d;
   logic             load_init_q, load_init_d;
   logic             round_en_q, round_en_d;
   logic             fin_key_pre_q, fin_key_pre_d;
   logic             xor_key_q, xor_key_d;
   logic             xor_lsb_q, xor_lsb_d;
   logic             blk_ready_q, blk_ready_d;
   logic             tag_valid_q, tag_valid_d;

   logic             blk_xfer;

   assign blk_xfer = blk_ready_q & bus.i_blk_valid;

   // Next state, counter and flags; outputs are decoded from the next state
   // so that they come straight out of flops and line up with the state.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      ad_phase_d    = ad_phase_q;
      blk_ad_last_d = blk_ad_last_q;

      unique case (state_q)
         IDLE: begin
            if (bus.i_start) begin
               ad_phase_d = bus.i_has_ad;
               state_d    = INIT_LOAD;
            end
         end
         INIT_LOAD: begin
            cnt_d   = '0;
            state_d = INIT_PERM;
         end
         INIT_PERM: begin
            if (cnt_q == LAST_IDX) begin
               cnt_d   = '0;
               state_d = INIT_XOR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         INIT_XOR: begin
            state_d = WAIT_BLK;
         end
         WAIT_BLK: begin
            if (blk_xfer) begin
               blk_ad_last_d = ad_phase_q & bus.i_blk_last;
               if (!ad_phase_q && bus.i_blk_last) begin
                  state_d = FIN_PRE;
               end else begin
                  cnt_d   = BLK_FIRST;
                  state_d = BLK_PERM;
               end
            end
         end
         BLK_PERM: begin
            if (cnt_q == LAST_IDX) begin
               cnt_d   = '0;
               state_d = blk_ad_last_q ? DSEP : WAIT_BLK;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DSEP: begin
            ad_phase_d    = 1'b0;
            blk_ad_last_d = 1'b0;
            state_d       = WAIT_BLK;
         end
         FIN_PRE: begin
            cnt_d   = '0;
            state_d = FIN_PERM;
         end
         FIN_PERM: begin
            if (cnt_q == LAST_IDX) begin
               cnt_d   = '0;
               state_d = FIN_XOR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         FIN_XOR: begin
            state_d = TAG;
         end
         TAG: begin
            if (bus.i_tag_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      ready_d       = (state_d == IDLE);
      load_init_d   = (state_d == INIT_LOAD);
      round_en_d    = (state_d == INIT_PERM) || (state_d == BLK_PERM) ||
                      (state_d == FIN_PERM);
      fin_key_pre_d = (state_d == FIN_PRE);
      xor_key_d     = (state_d == INIT_XOR) || (state_d == FIN_XOR);
      xor_lsb_d     = ((state_d == INIT_XOR) && !ad_phase_d) || (state_d == DSEP);
      blk_ready_d   = (state_d == WAIT_BLK);
      tag_valid_d   = (state_d == TAG);
   end

   // State, counter, flags and registered Moore outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         ad_phase_q    <= 1'b0;
         blk_ad_last_q <= 1'b0;
         ready_q       <= 1'b1;
         load_init_q   <= 1'b0;
         round_en_q    <= 1'b0;
         fin_key_pre_q <= 1'b0;
         xor_key_q     <= 1'b0;
         xor_lsb_q     <= 1'b0;
         blk_ready_q   <= 1'b0;
         tag_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         ad_phase_q    <= ad_phase_d;
         blk_ad_last_q <= blk_ad_last_d;
         ready_q       <= ready_d;
         load_init_q   <= load_init_d;
         round_en_q    <= round_en_d;
         fin_key_pre_q <= fin_key_pre_d;
         xor_key_q     <= xor_key_d;
         xor_lsb_q     <= xor_lsb_d;
         blk_ready_q   <= blk_ready_d;
         tag_valid_q   <= tag_valid_d;
      end
   end

   // The counter sits at 0 outside permutation states, so it doubles as
   // the round constant index output.
   assign bus.o_ready          = ready_q;
   assign bus.o_busy           = ~ready_q;
   assign bus.o_load_init      = load_init_q;
   assign bus.o_round_en       = round_en_q;
   assign bus.o_round_idx      = cnt_q;
   assign bus.o_fin_key_pre    = fin_key_pre_q;
   assign bus.o_enable_xor_key = xor_key_q;
   assign bus.o_enable_xor_lsb = xor_lsb_q;
   assign bus.o_blk_ready      = blk_ready_q;
   assign bus.o_absorb         = blk_xfer;
   assign bus.o_tag_valid      = tag_valid_q;

endmodule

// File: tb/tb_ascon_perm_sequencer.sv
// Directed bench for ascon_perm_sequencer: per-cycle hand-built timelines
// for two instances (ROUNDS_B=6 and ROUNDS_B=8).
module tb_ascon_perm_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   ascon_perm_sequencer_if #(.CNT_W(4)) if0 ();
   ascon_perm_sequencer_if #(.CNT_W(4)) if1 ();

   ascon_perm_sequencer #(.ROUNDS_A(12), .ROUNDS_B(6), .CNT_W(4)) dut0 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (if0)
   );

   ascon_perm_sequencer #(.ROUNDS_A(12), .ROUNDS_B(8), .CNT_W(4)) dut1 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (if1)
   );

   typedef struct packed {
      logic        start;
      logic        has_ad;
      logic        valid;
      logic        last;
      logic        tag_rdy;
      logic [13:0] exp;
   } step_t;

   step_t plan[$];
   int    n_checks = 0;
   int    n_errors = 0;
   logic  hold_start = 1'b0;
   logic  cur_ad = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // {ready, busy, load, round_en, idx[3:0], fin_pre, key, lsb, blk_ready, absorb, tag_valid}
   function automatic logic [13:0] ev(input logic rdy, input logic ld, input logic rnd,
                                      input logic [3:0] idx, input logic fin, input logic key,
                                      input logic lsb, input logic brdy, input logic abs,
                                      input logic tag);
      return {rdy, ~rdy, ld, rnd, idx, fin, key, lsb, brdy, abs, tag};
   endfunction

   function automatic logic [13:0] pack(input int sel);
      if (sel == 0)
         return {if0.o_ready, if0.o_busy, if0.o_load_init, if0.o_round_en, if0.o_round_idx,
                 if0.o_fin_key_pre, if0.o_enable_xor_key, if0.o_enable_xor_lsb,
                 if0.o_blk_ready, if0.o_absorb, if0.o_tag_valid};
      return {if1.o_ready, if1.o_busy, if1.o_load_init, if1.o_round_en, if1.o_round_idx,
              if1.o_fin_key_pre, if1.o_enable_xor_key, if1.o_enable_xor_lsb,
              if1.o_blk_ready, if1.o_absorb, if1.o_tag_valid};
   endfunction

   task automatic step(input logic st, input logic vld, input logic lst, input logic trdy,
                       input logic [13:0] e);
      step_t s;
      s.start   = st;
      s.has_ad  = cur_ad;
      s.valid   = vld;
      s.last    = lst;
      s.tag_rdy = trdy;
      s.exp     = e;
      plan.push_back(s);
   endtask

   task automatic add_rounds(input int unsigned first, input int unsigned n);
      for (int unsigned i = 0; i < n; i++)
         step(hold_start, 1'b1, 1'b0, 1'b0, ev(0, 0, 1, 4'(first + i), 0, 0, 0, 0, 0, 0));
   endtask

   task automatic add_init(input logic ad);
      cur_ad = ad;
      step(1'b1, 1'b1, 1'b0, 1'b0, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      step(hold_start, 1'b1, 1'b0, 1'b0, ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      add_rounds(0, 12);
      step(hold_start, 1'b1, 1'b0, 1'b0, ev(0, 0, 0, 0, 0, 1, ~ad, 0, 0, 0));
   endtask

   task automatic add_blk(input logic last, input int unsigned gap,
                          input int unsigned first, input int unsigned n);
      for (int unsigned i = 0; i < gap; i++)
         step(hold_start, 1'b0, 1'b0, 1'b0, ev(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      step(hold_start, 1'b1, last, 1'b0, ev(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
      add_rounds(first, n);
   endtask

   task automatic add_dsep();
      step(hold_start, 1'b1, 1'b0, 1'b0, ev(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
   endtask

   task automatic add_fin(input int unsigned tag_wait);
      step(hold_start, 1'b1, 1'b0, 1'b0, ev(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      add_rounds(0, 12);
      step(hold_start, 1'b1, 1'b0, 1'b0, ev(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      for (int unsigned i = 0; i < tag_wait; i++)
         step(hold_start, 1'b1, 1'b0, 1'b0, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      step(hold_start, 1'b1, 1'b0, 1'b1, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      step(hold_start, 1'b0, 1'b0, 1'b0, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
   endtask

   task automatic drive(input int sel, input step_t s);
      if0.i_start = 1'b0; if0.i_has_ad = 1'b0; if0.i_blk_valid = 1'b0;
      if0.i_blk_last = 1'b0; if0.i_tag_ready = 1'b0;
      if1.i_start = 1'b0; if1.i_has_ad = 1'b0; if1.i_blk_valid = 1'b0;
      if1.i_blk_last = 1'b0; if1.i_tag_ready = 1'b0;
      if (sel == 0) begin
         if0.i_start = s.start; if0.i_has_ad = s.has_ad; if0.i_blk_valid = s.valid;
         if0.i_blk_last = s.last; if0.i_tag_ready = s.tag_rdy;
      end else begin
         if1.i_start = s.start; if1.i_has_ad = s.has_ad; if1.i_blk_valid = s.valid;
         if1.i_blk_last = s.last; if1.i_tag_ready = s.tag_rdy;
      end
   endtask

   task automatic run_plan(input int sel, input int limit, input string name);
      for (int i = 0; i < plan.size() && i < limit; i++) begin
         @(negedge clk);
         drive(sel, plan[i]);
         #1;
         check($sformatf("%s_c%0d", name, i), 32'(pack(sel)), 32'(plan[i].exp));
      end
   endtask

   task automatic do_reset(input string name);
      step_t idle_s;
      idle_s = '0;
      @(negedge clk);
      drive(0, idle_s);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check({name, "_rst0"}, 32'(pack(0)), 32'(ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      check({name, "_rst1"}, 32'(pack(1)), 32'(ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      rst_n = 1'b1;
   endtask

   task automatic build_t1();
      plan.delete();
      hold_start = 1'b0;
      add_init(1'b0);
      add_blk(1'b1, 0, 0, 0);
      add_fin(0);
   endtask

   initial begin
      // T1: no AD, single data block, tag taken at once
      do_reset("t1");
      build_t1();
      run_plan(0, plan.size(), "t1");

      // T2: two AD blocks, two data blocks, ROUNDS_B=6
      do_reset("t2");
      plan.delete();
      add_init(1'b1);
      add_blk(1'b0, 0, 6, 6);
      add_blk(1'b1, 0, 6, 6);
      add_dsep();
      add_blk(1'b0, 0, 6, 6);
      add_blk(1'b1, 0, 0, 0);
      add_fin(0);
      run_plan(0, plan.size(), "t2");

      // T3: ROUNDS_B=8 instance, two data blocks
      do_reset("t3");
      plan.delete();
      add_init(1'b0);
      add_blk(1'b0, 0, 4, 8);
      add_blk(1'b1, 0, 0, 0);
      add_fin(0);
      run_plan(1, plan.size(), "t3");

      // T4: block source idle for 5 cycles in WAIT_BLK
      do_reset("t4");
      plan.delete();
      add_init(1'b0);
      add_blk(1'b0, 5, 6, 6);
      add_blk(1'b1, 5, 0, 0);
      add_fin(0);
      run_plan(0, plan.size(), "t4");

      // T5: start held high all pass, tag stalled 10 cycles; new pass only after IDLE
      do_reset("t5");
      plan.delete();
      hold_start = 1'b1;
      add_init(1'b0);
      add_blk(1'b1, 0, 0, 0);
      add_fin(10);
      plan[plan.size() - 1].start = 1'b1;
      step(1'b1, 1'b1, 1'b0, 1'b0, ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      hold_start = 1'b0;
      run_plan(0, plan.size(), "t5");

      // T6: async reset during FIN_PERM round 5, then a clean pass
      do_reset("t6");
      build_t1();
      run_plan(0, 23, "t6a");
      check("t6_pre_idx", 32'(if0.o_round_idx), 32'd5);
      #1;
      rst_n = 1'b0;
      #1;
      check("t6_async", 32'(pack(0)), 32'(ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_plan(0, plan.size(), "t6b");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ascon_perm_sequencer.md
Name: ascon_perm_sequencer

Overview:
- FSM sequencing the Ascon permutation datapath and its end-of-permutation XOR stage through one full AEAD pass.
- Pass order: state init load → p^a → key/domain XOR → AD/data block absorption with p^b → finalization → tag.
- Issues one round enable per cycle with round-constant index, key/LSB XOR enables, absorb/load strobes, block and tag handshakes.
- Sits between the top-level AEAD control and the permutation/XOR datapath. It holds no state data itself.

Parameters:
- ROUNDS_A, 12, rounds for init and finalization permutation p^a.
- ROUNDS_B, 6, rounds for block permutation p^b (8 for the 128a variant); legal 1..ROUNDS_A.
- CNT_W, 4, round counter width; must satisfy 2^CNT_W > ROUNDS_A.

Ports:
- i_clk input 1 clock, rising edge.
- i_rst_n input 1 reset, asynchronous, active-low.
- i_start input 1 start request; accepted when i_start & o_ready.
- i_has_ad input 1 associated data present; sampled only with accepted start.
- i_blk_valid input 1 block available at datapath input.
- i_blk_last input 1 qualifies i_blk_valid: last block of current phase (AD or data).
- o_blk_ready output 1 sequencer accepts block this cycle.
- o_load_init output 1 datapath loads IV||K||N into state.
- o_absorb output 1 datapath XORs block into x0(/x1); equals block transfer.
- o_round_en output 1 apply one permutation round this cycle.
- o_round_idx output CNT_W round constant index i (0..ROUNDS_A-1).
- o_fin_key_pre output 1 XOR key into x1..x2 before finalization.
- o_enable_xor_key output 1 drives end-XOR key enable.
- o_enable_xor_lsb output 1 drives end-XOR LSB (domain separation) enable.
- o_tag_valid output 1 tag available in x3..x4.
- i_tag_ready input 1 consumer takes tag.
- o_ready output 1 idle, new start accepted.
- o_busy output 1 pass in progress (= !o_ready).

Behaviour:
- Registered state and round counter. All outputs decoded from state/counter (Moore), except o_absorb = o_blk_ready & i_blk_valid.
- Reset (async, any time, including mid-pass): state IDLE, counter 0, ad_phase 0.
  - o_ready=1; every other output 0; o_round_idx=0.
  - No partial-pass recovery.
- States and transitions:
  - IDLE: o_ready=1. On i_start, latch ad_phase=i_has_ad → INIT_LOAD. i_start is ignored in every other state.
  - INIT_LOAD (1 cycle): o_load_init=1 → INIT_PERM, counter=0.
  - INIT_PERM (ROUNDS_A cycles): o_round_en=1, o_round_idx=counter, counter increments. After idx ROUNDS_A-1 → INIT_XOR.
  - INIT_XOR (1 cycle): o_enable_xor_key=1. If ad_phase=0, also o_enable_xor_lsb=1 in the same cycle. → WAIT_BLK.
  - WAIT_BLK: o_blk_ready=1. On transfer:
    - ad_phase=1 → BLK_PERM, counter=ROUNDS_A-ROUNDS_B.
    - ad_phase=0 & !last → BLK_PERM, counter=ROUNDS_A-ROUNDS_B.
    - ad_phase=0 & last → FIN_PRE.
  - BLK_PERM (ROUNDS_B cycles): o_round_en=1, o_round_idx=counter, idx ROUNDS_A-ROUNDS_B..ROUNDS_A-1. On completion:
    - if the absorbed block was AD & last → DSEP;
    - else → WAIT_BLK.
  - DSEP (1 cycle): o_enable_xor_lsb=1, clear ad_phase → WAIT_BLK.
  - FIN_PRE (1 cycle): o_fin_key_pre=1 → FIN_PERM, counter=0.
  - FIN_PERM (ROUNDS_A cycles): same as INIT_PERM → FIN_XOR.
  - FIN_XOR (1 cycle): o_enable_xor_key=1, o_enable_xor_lsb=0 → TAG.
  - TAG: o_tag_valid=1, held until i_tag_ready → IDLE. Start earliest the cycle after return.
- Block-kind flag: registered at transfer (ad_phase & last) for the BLK_PERM exit decision.
- Handshake rules:
  - o_blk_ready is 0 outside WAIT_BLK.
  - i_blk_valid outside WAIT_BLK is ignored, not dropped: the source holds it.
  - Empty AD requires i_has_ad=0.
  - The data phase always consumes ≥1 block (padded empty block with last=1).
- Never asserted together: o_round_en with any XOR/load/absorb strobe. o_enable_xor_lsb with o_enable_xor_key occurs only in INIT_XOR.
- Counter: resets to 0 entering INIT_PERM/FIN_PERM and never wraps past ROUNDS_A-1.
- Latency, no AD, one data block: start accepted at cycle 0 gives:
  - INIT_LOAD at 1;
  - rounds at 2–13;
  - INIT_XOR at 14;
  - block accepted earliest at 15;
  - FIN_PRE at 16;
  - rounds at 17–28;
  - FIN_XOR at 29;
  - o_tag_valid from 30.

Test Plan:
- Reset, then i_start with i_has_ad=0 and one data block (last=1) ready, i_tag_ready=1 → timing exactly per latency above; round_idx 0..11 twice; lsb and key both high at cycle 14; tag_valid for one cycle at 30; o_ready at 31.
- i_has_ad=1, 2 AD blocks (2nd last), 2 data blocks, ROUNDS_B=6 → two 6-round bursts with idx 6..11, single DSEP lsb pulse, one more 6-round burst after data block 1, then FIN_PRE after data block 2.
- ROUNDS_B=8 run → block bursts use idx 4..11.
- i_blk_valid toggled low in WAIT_BLK for 5 cycles → FSM holds, no o_absorb, no round enables; proceeds on valid.
- TAG held with i_tag_ready=0 for 10 cycles, i_start=1 throughout → tag_valid stable, start ignored until return to IDLE.
- i_rst_n low during FIN_PERM round 5 → all outputs 0 asynchronously, o_ready=1; new pass after release runs a clean full sequence.
